// File: rtl/fft_state3_ctrl.sv
// Stage-3 MDC FFT sequencer: counts input pairs, schedules commutator, butterfly,
// multiplier and twiddle index, and flags output-valid / frame-done / broken frames.
module fft_state3_ctrl #(
  parameter int FRAME_CYC = 16,
  parameter int SHIFT     = 4,
  parameter int LAT       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic [4:0] state_com_mode,
  output logic [6:0] state_code,
  output logic       butter_mode,
  output logic       mul_mode,
  output logic [1:0] rom_4_counter,
  output logic       out_valid,
  output logic       frame_done,
  output logic       err
);

  localparam int CW = $clog2(FRAME_CYC);
  localparam int SB = $clog2(SHIFT);
  localparam int DW = $clog2(LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYC - 1);
  localparam logic [DW-1:0] DRN_LAST = DW'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [2:0]      frame_id_r, frame_id_nxt_s;
  logic [DW-1:0]   drn_r, drn_nxt_s;
  logic            abort_s;
  logic            bmode_s;

  logic [SHIFT-1:0] bv_pipe_r;
  logic [SB:0]      bc_pipe_r [SHIFT];
  logic [LAT-1:0]   ov_pipe_r;
  logic [CW-1:0]    oc_pipe_r [LAT];
  logic             err_r;

  // FSM state, input counter, frame id and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      frame_id_r <= 3'd0;
      drn_r      <= {DW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      frame_id_r <= frame_id_nxt_s;
      drn_r      <= drn_nxt_s;
    end
  end

  // Next-state, counter and abort decode
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    frame_id_nxt_s = frame_id_r;
    abort_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (in_valid) begin
          state_nxt_s = RUN;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = DRAIN;
        end else begin
          // broken frame: drop back to IDLE and flush pending output valids
          abort_s     = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (in_valid)               state_nxt_s = RUN;
        else if (drn_r == DRN_LAST) state_nxt_s = IDLE;
        else                        state_nxt_s = DRAIN;
      end
      default: state_nxt_s = IDLE;
    endcase

    if (abort_s) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (in_valid) begin
      if (cnt_r == CNT_LAST) begin
        cnt_nxt_s      = {CW{1'b0}};
        frame_id_nxt_s = frame_id_r + 3'd1;
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end

    if (state_r == DRAIN) drn_nxt_s = drn_r + DW'(1);
    else                  drn_nxt_s = {DW{1'b0}};
  end

  // Butterfly schedule pipe, output-valid pipe and error pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bv_pipe_r <= {SHIFT{1'b0}};
      ov_pipe_r <= {LAT{1'b0}};
      err_r     <= 1'b0;
      for (int i = 0; i < SHIFT; i++) bc_pipe_r[i] <= {(SB+1){1'b0}};
      for (int i = 0; i < LAT; i++)   oc_pipe_r[i] <= {CW{1'b0}};
    end else begin
      bv_pipe_r    <= {bv_pipe_r[SHIFT-2:0], in_valid};
      bc_pipe_r[0] <= cnt_r[SB:0];
      for (int i = 1; i < SHIFT; i++) bc_pipe_r[i] <= bc_pipe_r[i-1];
      if (abort_s) begin
        ov_pipe_r <= {LAT{1'b0}};
        for (int i = 0; i < LAT; i++) oc_pipe_r[i] <= {CW{1'b0}};
      end else begin
        ov_pipe_r    <= {ov_pipe_r[LAT-2:0], in_valid};
        oc_pipe_r[0] <= cnt_r;
        for (int i = 1; i < LAT; i++) oc_pipe_r[i] <= oc_pipe_r[i-1];
      end
      err_r <= abort_s;
    end
  end

  // Datapath controls decoded from registered state
  always_comb begin
    if (state_r == RUN && in_valid && cnt_r[SB]) state_com_mode = 5'b00010;
    else                                        state_com_mode = 5'b00001;
    state_code  = {frame_id_r, cnt_r};
    bmode_s     = bv_pipe_r[SHIFT-1] & ~bc_pipe_r[SHIFT-1][SB];
    butter_mode = bmode_s;
    mul_mode    = bmode_s;
    if (bmode_s) rom_4_counter = bc_pipe_r[SHIFT-1][1:0];
    else         rom_4_counter = 2'd0;
    out_valid   = ov_pipe_r[LAT-1];
    frame_done  = ov_pipe_r[LAT-1] & (oc_pipe_r[LAT-1] == CNT_LAST);
    err         = err_r;
  end

endmodule

// File: tb/tb_fft_state3_ctrl.sv
// Self-checking bench for fft_state3_ctrl: directed scenarios plus random in_valid
// traffic, compared against a sample-history reference model.
module tb_fft_state3_ctrl;
  localparam int SHIFT = 4;
  localparam int LAT   = 8;
  localparam int HMAX  = 4096;
  localparam logic [18:0] RST_VEC = {5'b00001, 7'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] state_com_mode;
  logic [6:0] state_code;
  logic       butter_mode, mul_mode, out_valid, frame_done, err;
  logic [1:0] rom_4_counter;

  fft_state3_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .state_com_mode(state_com_mode), .state_code(state_code),
    .butter_mode(butter_mode), .mul_mode(mul_mode), .rom_4_counter(rom_4_counter),
    .out_valid(out_valid), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  wire [18:0] dut_vec = {state_com_mode, state_code, butter_mode, mul_mode,
                         rom_4_counter, out_valid, frame_done, err};

  int n_cmp = 0;
  int n_bad = 0;

  // model: per-cycle history of input valid, sample position and aborts
  bit  iv_h [HMAX];
  int  pos_h [HMAX];
  bit  ab_h [HMAX];
  int  t, m_pos, m_fid;
  logic [18:0] exp_vec;

  task automatic model_reset();
    t = 0; m_pos = 0; m_fid = 0;
  endtask

  // drive one cycle of in_valid, then compute this cycle's expected outputs
  task automatic drive(input logic v);
    logic [4:0] e_com;
    logic [6:0] e_code;
    logic       e_bm, e_ov, e_fd, e_err;
    logic [1:0] e_rom;
    @(negedge clk);
    in_valid = v;
    #1;
    if (t >= HMAX) begin
      $display("FAIL model_overflow t=%0d limit=%0d", t, HMAX);
      $fatal(1);
    end
    e_code = 7'(m_fid * 16 + m_pos);
    e_com  = (v && (m_pos % 8) >= 4) ? 5'b00010 : 5'b00001;
    e_bm = 1'b0; e_rom = 2'd0;
    if (t >= SHIFT && iv_h[t-SHIFT] && (pos_h[t-SHIFT] % 8) < 4) begin
      e_bm  = 1'b1;
      e_rom = 2'(pos_h[t-SHIFT] % 4);
    end
    e_ov = 1'b0;
    if (t >= LAT && iv_h[t-LAT]) begin
      e_ov = 1'b1;
      for (int a = t - LAT; a < t; a++) if (ab_h[a]) e_ov = 1'b0;
    end
    e_fd  = e_ov && (pos_h[t-LAT] == 15);
    e_err = (t >= 1) && ab_h[t-1];
    exp_vec = {e_com, e_code, e_bm, e_bm, e_rom, e_ov, e_fd, e_err};
    iv_h[t] = v; pos_h[t] = m_pos; ab_h[t] = 1'b0;
    if (v) begin
      m_pos++;
      if (m_pos == 16) begin m_pos = 0; m_fid = (m_fid + 1) % 8; end
    end else if (m_pos != 0) begin
      ab_h[t] = 1'b1;
      m_pos = 0;
    end
    t++;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (dut_vec !== RST_VEC) begin
      n_bad++; $display("FAIL reset_state got %h want %h", dut_vec, RST_VEC);
    end
    drive(1'b0);
    n_cmp++;
    if (dut_vec !== exp_vec) begin
      n_bad++; $display("FAIL reset_idle got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_single_frame();
    int ov_n = 0, bm_n = 0, fd_n = 0;
    for (int c = 0; c < 30; c++) begin
      drive(c < 16);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL single_c%0d got %h want %h", c, dut_vec, exp_vec);
      end
      ov_n += int'(out_valid);
      bm_n += int'(butter_mode);
      if (frame_done) begin
        fd_n++;
        n_cmp++;
        if (c != 23) begin n_bad++; $display("FAIL single_fd_cycle got %0d want 23", c); end
      end
    end
    n_cmp++;
    if (ov_n != 16) begin n_bad++; $display("FAIL single_ov_count got %0d want 16", ov_n); end
    n_cmp++;
    if (bm_n != 8) begin n_bad++; $display("FAIL single_bm_count got %0d want 8", bm_n); end
    n_cmp++;
    if (fd_n != 1) begin n_bad++; $display("FAIL single_fd_count got %0d want 1", fd_n); end
  endtask

  task automatic test_back_to_back();
    int base = m_fid;
    int ov_n = 0, fd_n = 0;
    for (int c = 0; c < 64; c++) begin
      drive(c < 48);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL b2b_c%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (c % 16 == 0 && c < 48) begin
        n_cmp++;
        if (int'(state_code[6:4]) != (base + c / 16) % 8) begin
          n_bad++; $display("FAIL b2b_fid_c%0d got %0d want %0d", c, state_code[6:4], (base + c / 16) % 8);
        end
      end
      ov_n += int'(out_valid);
      if (frame_done) begin
        fd_n++;
        n_cmp++;
        if (c != 23 && c != 39 && c != 55) begin
          n_bad++; $display("FAIL b2b_fd_cycle got %0d want 23/39/55", c);
        end
      end
    end
    n_cmp++;
    if (ov_n != 48) begin n_bad++; $display("FAIL b2b_ov_count got %0d want 48", ov_n); end
    n_cmp++;
    if (fd_n != 3) begin n_bad++; $display("FAIL b2b_fd_count got %0d want 3", fd_n); end
  endtask

  task automatic test_mid_drop();
    int ov_n = 0, fd_n = 0, err_n = 0;
    for (int c = 0; c < 24; c++) begin
      drive(c < 9);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL drop_c%0d got %h want %h", c, dut_vec, exp_vec);
      end
      ov_n  += int'(out_valid);
      fd_n  += int'(frame_done);
      if (err) begin
        err_n++;
        n_cmp++;
        if (c != 10) begin n_bad++; $display("FAIL drop_err_cycle got %0d want 10", c); end
      end
    end
    n_cmp++;
    if (err_n != 1) begin n_bad++; $display("FAIL drop_err_count got %0d want 1", err_n); end
    n_cmp++;
    if (ov_n != 2) begin n_bad++; $display("FAIL drop_ov_count got %0d want 2", ov_n); end
    n_cmp++;
    if (fd_n != 0) begin n_bad++; $display("FAIL drop_fd_count got %0d want 0", fd_n); end
    for (int c = 0; c < 28; c++) begin
      drive(c < 16);
      if (c == 0) begin
        n_cmp++;
        if (state_code[3:0] !== 4'd0) begin
          n_bad++; $display("FAIL drop_restart_cnt got %0d want 0", state_code[3:0]);
        end
      end
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL drop_next_c%0d got %h want %h", c, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int c = 0; c < 8; c++) drive(1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== RST_VEC) begin
      n_bad++; $display("FAIL rstmid_state got %h want %h", dut_vec, RST_VEC);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 28; c++) begin
      drive(c < 16);
      if (c == 0) begin
        n_cmp++;
        if (state_code !== 7'd0) begin
          n_bad++; $display("FAIL rstmid_first_code got %0d want 0", state_code);
        end
      end
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL rstmid_c%0d got %h want %h", c, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_frame_wrap();
    do_reset();
    for (int c = 0; c < 156; c++) begin
      drive(c < 144);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL wrap_c%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (c % 16 == 0 && c < 144) begin
        n_cmp++;
        if (int'(state_code[6:4]) != (c / 16) % 8) begin
          n_bad++; $display("FAIL wrap_fid_f%0d got %0d want %0d", c / 16, state_code[6:4], (c / 16) % 8);
        end
      end
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    int len;
    int kind;
    while (cyc < 700) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       len = int'($urandom_range(0, 12));
        1, 2:    len = 16;
        default: len = int'($urandom_range(1, 15));
      endcase
      for (int i = 0; i < len; i++) begin
        drive(kind != 0);
        cyc++;
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_bad++; $display("FAIL rand_t%0d got %h want %h", t - 1, dut_vec, exp_vec);
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL rand_tail_t%0d got %h want %h", t - 1, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_mid_drop();
    test_reset_mid_run();
    test_frame_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
